// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bundle: imem request/ack, decode valid/ready,
// execute redirect, next-PC controls and status flags.
interface fetch_sequencer_if;
  logic        imem_req;
  logic        imem_ack;
  logic        instr_valid;
  logic        dec_ready;
  logic        redirect_valid;
  logic        branch_taken;
  logic        jal;
  logic        jalr;
  logic [1:0]  target_lsb;
  logic [1:0]  pc_src;
  logic        pc_en;
  logic        flush;
  logic [31:0] fetch_count;
  logic        timeout;
  logic        trap;

  modport master (
    output imem_req,
    output instr_valid,
    output pc_src,
    output pc_en,
    output flush,
    output fetch_count,
    output timeout,
    output trap,
    input  imem_ack,
    input  dec_ready,
    input  redirect_valid,
    input  branch_taken,
    input  jal,
    input  jalr,
    input  target_lsb
  );

  modport slave (
    input  imem_req,
    input  instr_valid,
    input  pc_src,
    input  pc_en,
    input  flush,
    input  fetch_count,
    input  timeout,
    input  trap,
    output imem_ack,
    output dec_ready,
    output redirect_valid,
    output branch_taken,
    output jal,
    output jalr,
    output target_lsb
  );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: RV32 PC-datapath controller. Sequences imem
// req/ack and decode valid/ready, drives next-PC select/load enable,
// applies execute redirects and runs an imem stall watchdog.
// Ports: clk; reset (async, active-high); fs (fetch_sequencer_if.master):
//   imem_req/imem_ack, instr_valid/dec_ready, redirect_valid +
//   branch_taken/jal/jalr + target_lsb, pc_src, pc_en, flush,
//   fetch_count, timeout, trap.
// MAX_STALL: un-acked FETCH cycles before timeout (1..65535).
// Optional macro FETCH_MISALIGN_TRAP_EN: misaligned redirect halts.
module fetch_sequencer #(
  parameter int unsigned MAX_STALL = 255
) (
  input logic              clk,
  input logic              reset,
  fetch_sequencer_if.master fs
);

  localparam logic [15:0] MaxStall = 16'(MAX_STALL);

  localparam logic [1:0] SrcPlus4  = 2'b00;
  localparam logic [1:0] SrcTarget = 2'b01;
  localparam logic [1:0] SrcAlu    = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD,
    S_HALT
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] stall_q, stall_d;
  logic [15:0] stall_inc;
  logic [31:0] cnt_q, cnt_d;
  logic        timeout_q, timeout_d;

  logic        live;
  logic        redir_req;
  logic [1:0]  redir_src;
  logic        pc_en_c;
  logic [1:0]  pc_src_c;
  logic        flush_c;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic        trap_q, trap_d;
  logic        misalign;
  assign misalign = (fs.target_lsb != 2'b00);
`else
  logic        unused_lsb;
  assign unused_lsb = ^fs.target_lsb;
`endif

  // Redirects only matter while a fetch or instruction is in flight.
  assign live = (state_q == S_FETCH) ||
                (state_q == S_HOLD);

  // A redirect with no qualifier is a not-taken branch.
  assign redir_req = fs.redirect_valid &
                     (fs.branch_taken | fs.jal | fs.jalr);

  // jalr wins over jal/branch; those two share PCTarget.
  always_comb begin
    redir_src = SrcTarget;
    if (fs.jalr) begin
      redir_src = SrcAlu;
    end
  end

  assign stall_inc = stall_q + 16'd1;

  always_comb begin
    state_d   = state_q;
    stall_d   = stall_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    trap_d    = trap_q;
`endif
    pc_en_c   = 1'b0;
    pc_src_c  = SrcPlus4;
    flush_c   = 1'b0;

    if (live && redir_req) begin
      // Same-cycle ack / dec_ready are dropped by the flush.
      flush_c = 1'b1;
      stall_d = '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (misalign) begin
        trap_d  = 1'b1;
        state_d = S_HALT;
      end else begin
        pc_en_c  = 1'b1;
        pc_src_c = redir_src;
        state_d  = S_FETCH;
      end
`else
      pc_en_c  = 1'b1;
      pc_src_c = redir_src;
      state_d  = S_FETCH;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          stall_d = '0;
          state_d = S_FETCH;
        end
        S_FETCH: begin
          if (fs.imem_ack) begin
            stall_d = '0;
            state_d = S_HOLD;
          end else if (stall_inc == MaxStall) begin
            stall_d   = '0;
            timeout_d = 1'b1;
            state_d   = S_HALT;
          end else begin
            stall_d = stall_inc;
          end
        end
        S_HOLD: begin
          if (fs.dec_ready) begin
            pc_en_c = 1'b1;
            cnt_d   = cnt_q + 32'd1;
            state_d = S_FETCH;
          end
        end
        S_HALT: begin
          state_d = S_HALT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      stall_q   <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      stall_q   <= stall_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trap_q <= 1'b0;
    end else begin
      trap_q <= trap_d;
    end
  end
  assign fs.trap = trap_q;
`else
  assign fs.trap = 1'b0;
`endif

  assign fs.imem_req    = (state_q == S_FETCH);
  assign fs.instr_valid = (state_q == S_HOLD);
  assign fs.pc_en       = pc_en_c;
  assign fs.pc_src      = pc_src_c;
  assign fs.flush       = flush_c;
  assign fs.fetch_count = cnt_q;
  assign fs.timeout     = timeout_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed table, corner
// sequences and randomized run against a behavioural model.
module tb_fetch_sequencer;

  localparam int MS = 4;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fetch_sequencer_if sb ();

  fetch_sequencer #(.MAX_STALL(MS)) dut (
    .clk   (clk),
    .reset (reset),
    .fs    (sb)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // {imem_req, instr_valid, pc_en, pc_src[1:0], flush}
  function automatic logic [5:0] outs();
    return {sb.imem_req, sb.instr_valid, sb.pc_en,
            sb.pc_src, sb.flush};
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h @%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ack, dr, rv,
                       input logic bt, jl, jr,
                       input logic [1:0] lsb);
    sb.imem_ack       = ack;
    sb.dec_ready      = dr;
    sb.redirect_valid = rv;
    sb.branch_taken   = bt;
    sb.jal            = jl;
    sb.jalr           = jr;
    sb.target_lsb     = lsb;
  endtask

  // ---------------- behavioural model ----------------
  bit          m_run, m_halt, m_hold;
  int          m_stall;
  logic [31:0] m_cnt;
  bit          m_to, m_trap;

  task automatic model_reset();
    m_run = 0; m_halt = 0; m_hold = 0;
    m_stall = 0; m_cnt = '0; m_to = 0; m_trap = 0;
  endtask

  // Gives this cycle's expected outs(), then advances one clock.
  task automatic model_step(input logic ack, dr, rv,
                            input logic bt, jl, jr,
                            input logic [1:0] lsb,
                            output logic [5:0] e);
    bit act, fetching, holding, taken, mis;
    act      = m_run && !m_halt;
    fetching = act && !m_hold;
    holding  = act && m_hold;
    taken    = act && rv && (bt || jl || jr);
    mis      = TRAP_EN && (lsb != 2'b00);
    e = '0;
    e[5] = fetching;
    e[4] = holding;
    if (taken) begin
      e[0] = 1'b1;
      if (mis) begin
        m_halt = 1; m_trap = 1;
      end else begin
        e[3]   = 1'b1;
        e[2:1] = jr ? 2'd2 : 2'd1;
      end
      m_hold = 0; m_stall = 0;
    end else if (fetching) begin
      if (ack) begin
        m_hold = 1; m_stall = 0;
      end else begin
        m_stall++;
        if (m_stall >= MS) begin
          m_to = 1; m_halt = 1; m_stall = 0;
        end
      end
    end else if (holding && dr) begin
      e[3]  = 1'b1;
      m_cnt = m_cnt + 32'd1;
      m_hold = 0;
    end
    if (!m_run) m_run = 1;
  endtask

  // ---------------- directed table ----------------
  typedef struct packed {
    logic       ack, dr, rv, bt, jl, jr;
    logic [1:0] lsb;
    logic [5:0] e;
    logic [31:0] cnt;
    logic       trap;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(input logic [5:0] in6,
                              input logic [1:0] lsb,
                              input logic [5:0] e,
                              input logic [31:0] cnt,
                              input logic trap);
    vec_t v;
    {v.ack, v.dr, v.rv, v.bt, v.jl, v.jr} = in6;
    v.lsb = lsb; v.e = e; v.cnt = cnt; v.trap = trap;
    return v;
  endfunction

  // Asserts reset at a negedge, checks, releases at next negedge.
  task automatic do_reset(input string nm);
    @(negedge clk);
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 2'b00);
    #1;
    chk({nm, "_outs"},
        {24'd0, outs(), sb.timeout, sb.trap}, 32'd0);
    chk({nm, "_cnt"}, sb.fetch_count, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [5:0] e;
    logic [31:0] ecnt;
    logic ecto, ectr;
    logic ack, dr, rv, bt, jl, jr;
    logic [1:0] lsb;
    int halt_cyc;

    drive(0, 0, 0, 0, 0, 0, 2'b00);
    // in6 = {ack, dr, rv, bt, jal, jalr}; e = {req,val,pen,src,fl}
    tbl[0]  = mk(6'b000000, 2'b00, 6'b000000, 0, 0);
    tbl[1]  = mk(6'b100000, 2'b00, 6'b100000, 0, 0);
    tbl[2]  = mk(6'b010000, 2'b00, 6'b011000, 0, 0);
    tbl[3]  = mk(6'b100000, 2'b00, 6'b100000, 1, 0);
    tbl[4]  = mk(6'b000000, 2'b00, 6'b010000, 1, 0);
    tbl[5]  = mk(6'b000000, 2'b00, 6'b010000, 1, 0);
    tbl[6]  = mk(6'b000000, 2'b00, 6'b010000, 1, 0);
    tbl[7]  = mk(6'b000000, 2'b00, 6'b010000, 1, 0);
    tbl[8]  = mk(6'b010000, 2'b00, 6'b011000, 1, 0);
    tbl[9]  = mk(6'b000000, 2'b00, 6'b100000, 2, 0);
    tbl[10] = mk(6'b100000, 2'b00, 6'b100000, 2, 0);
    tbl[11] = mk(6'b011011, 2'b00, 6'b011101, 2, 0);
    tbl[12] = mk(6'b101000, 2'b00, 6'b100000, 2, 0);
    tbl[13] = mk(6'b010000, 2'b00, 6'b011000, 2, 0);
    tbl[14] = mk(6'b101100, 2'b10,
                 TRAP_EN ? 6'b100001 : 6'b101011, 3, 0);
    tbl[15] = mk(6'b000000, 2'b00,
                 TRAP_EN ? 6'b000000 : 6'b100000, 3, TRAP_EN);

    do_reset("rst0");
    foreach (tbl[i]) begin
      drive(tbl[i].ack, tbl[i].dr, tbl[i].rv,
            tbl[i].bt, tbl[i].jl, tbl[i].jr, tbl[i].lsb);
      #1;
      chk($sformatf("tbl%0d_outs", i),
          {26'd0, outs()}, {26'd0, tbl[i].e});
      chk($sformatf("tbl%0d_cnt", i),
          sb.fetch_count, tbl[i].cnt);
      chk($sformatf("tbl%0d_trap", i),
          {31'd0, sb.trap}, {31'd0, tbl[i].trap});
      @(negedge clk);
    end

    // Watchdog: MS un-acked FETCH cycles, then HALT.
    do_reset("rst_wd");
    drive(0, 0, 0, 0, 0, 0, 2'b00);
    @(negedge clk);
    for (int k = 0; k < MS; k++) begin
      #1;
      chk($sformatf("wd_fetch%0d", k),
          {30'd0, sb.imem_req, sb.timeout}, 32'd2);
      @(negedge clk);
    end
    #1;
    chk("wd_timeout", {30'd0, sb.imem_req, sb.timeout}, 32'd1);
    for (int k = 0; k < 2; k++) begin
      drive(1, 1, 1, 1, 1, 0, 2'b00);
      #1;
      chk($sformatf("halt_redir%0d", k),
          {26'd0, outs()}, 32'd0);
      @(negedge clk);
    end
    do_reset("rst_wdclr");

    // Asynchronous reset while HOLD with dec_ready high.
    drive(0, 0, 0, 0, 0, 0, 2'b00);
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 2'b00);
    @(negedge clk);
    drive(0, 1, 0, 0, 0, 0, 2'b00);
    #1;
    chk("mid_hold_pen", {26'd0, outs()}, {26'd0, 6'b011000});
    reset = 1'b1;
    #1;
    chk("async_rst", {26'd0, outs()}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // fetch_count wrap.
    do_reset("rst_wrap");
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_q;
    #1;
    chk("wrap_pre", sb.fetch_count, 32'hFFFF_FFFF);
    drive(0, 0, 0, 0, 0, 0, 2'b00);
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 2'b00);
    @(negedge clk);
    drive(0, 1, 0, 0, 0, 0, 2'b00);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 2'b00);
    #1;
    chk("wrap_post", sb.fetch_count, 32'd0);

    // Randomized run against the model.
    do_reset("rst_rand");
    halt_cyc = 0;
    for (int n = 0; n < 3000; n++) begin
      if (m_halt) halt_cyc++;
      if (halt_cyc > 3 || $urandom_range(199) == 0) begin
        do_reset("rst_r");
        halt_cyc = 0;
      end
      ack = ($urandom_range(99) < 55);
      dr  = ($urandom_range(99) < 60);
      rv  = ($urandom_range(99) < 15);
      bt  = $urandom_range(1);
      jl  = $urandom_range(1);
      jr  = $urandom_range(1);
      lsb = ($urandom_range(99) < 80) ? 2'b00
                                      : 2'($urandom_range(3));
      drive(ack, dr, rv, bt, jl, jr, lsb);
      #1;
      ecnt = m_cnt;
      ecto = m_to;
      ectr = m_trap;
      model_step(ack, dr, rv, bt, jl, jr, lsb, e);
      chk($sformatf("rnd%0d_outs", n),
          {26'd0, outs()}, {26'd0, e});
      chk($sformatf("rnd%0d_cnt", n), sb.fetch_count, ecnt);
      chk($sformatf("rnd%0d_flags", n),
          {30'd0, sb.timeout, sb.trap}, {30'd0, ecto, ectr});
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Controller for the RV32 program-counter datapath (PC register, PC+4 adder, 3:1 next-PC mux). Sequences instruction fetch through a request/acknowledge handshake with instruction memory and a valid/ready handshake with decode. Generates the next-PC mux select and a PC load enable, applies execute-stage redirects (branch/JAL/JALR), and raises a sticky flag if memory stalls too long.

## Interface
- MAX_STALL, 255: cycles FETCH may wait for imem_ack before timeout; legal range 1..65535.

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- imem_req  out  1  fetch request at current PC
- imem_ack  in  1  single-cycle pulse: instruction word available; ignored unless imem_req=1
- instr_valid  out  1  fetched instruction valid to decode
- dec_ready  in  1  decode accepts instruction
- redirect_valid  in  1  execute stage presents a resolved control transfer this cycle
- branch_taken  in  1  qualifier: conditional branch taken (PCTarget)
- jal  in  1  qualifier: JAL (PCTarget)
- jalr  in  1  qualifier: JALR (ALUResult)
- target_lsb  in  2  bits [1:0] of selected redirect target
- pc_src  out  2  next-PC mux select: 00 PC+4, 01 PCTarget, 10 ALUResult; 11 never driven
- pc_en  out  1  PC register load enable, PC updates at the edge where pc_en=1
- flush  out  1  one-cycle pulse: in-flight fetch/instruction discarded
- fetch_count  out  32  accepted instructions (instr_valid & dec_ready & no redirect), wraps 0xFFFFFFFF->0
- timeout  out  1  sticky watchdog flag
- trap  out  1  sticky misaligned-target flag (constant 0 when macro absent)

## Operation
- States: IDLE, FETCH, HOLD, HALT.
- Reset: state IDLE; instr_valid, flush, timeout, trap, fetch_count, stall counter = 0; pc_src=00, pc_en=0, imem_req=0.
- IDLE: one cycle, then FETCH unconditionally (PC already 0 from PC reset).
- FETCH: imem_req=1. imem_ack -> HOLD. Stall counter increments each FETCH cycle without ack; clears on ack or leaving FETCH.
- HOLD: instr_valid=1, imem_req=0. dec_ready -> pc_en=1, pc_src=00, fetch_count+1, -> FETCH.
- Redirect (redirect_valid=1 with any qualifier set), any of FETCH/HOLD: highest priority. pc_en=1; pc_src=10 if jalr, else 01 (jalr > jal > branch_taken). flush=1 same cycle; any same-cycle imem_ack or dec_ready discarded (no count increment); -> FETCH, stall counter cleared.
- redirect_valid=1 with no qualifier: treated as not-taken, ignored.
- Redirect in IDLE or HALT: ignored.
- Watchdog: stall counter reaching MAX_STALL -> timeout=1, -> HALT. HALT: all handshake outputs 0, pc_en=0; exit only by reset.
- pc_src = 00 whenever pc_en=0.

## Timing
- pc_en, pc_src, flush, imem_req, instr_valid: combinational from state and current inputs (Mealy for pc_en/pc_src/flush); no output exceeds one flop + one logic level from inputs.
- Fetch latency: ack in cycle N -> instr_valid high cycle N+1. Zero-wait decode: HOLD->FETCH in 1 cycle; best throughput 1 instruction per 2 cycles.
- Redirect in cycle N -> PC holds target at N+1, imem_req=1 at N+1.
- Timeout: MAX_STALL consecutive un-acked FETCH cycles -> timeout=1 in the next cycle.
- Reset asserted mid-fetch: outputs reach reset values immediately (asynchronous); release -> IDLE one cycle, FETCH next.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined: redirect with target_lsb != 00 does not load PC (pc_en=0), asserts flush, sets trap=1, -> HALT until reset. Check applies after qualifier priority.
- Undefined: target_lsb ignored, trap tied 0, misaligned targets redirected normally.

## Test plan
- Reset release, imem_ack every FETCH cycle, dec_ready=1 -> pc_en pulses every 2nd cycle, pc_src=00, fetch_count=5 after 5 handshakes.
- HOLD with dec_ready=0 for 4 cycles -> instr_valid stays 1, pc_en=0, fetch_count unchanged; then dec_ready=1 -> one pc_en pulse.
- Redirect jal=1 and jalr=1 same cycle as dec_ready=1 in HOLD -> pc_src=10, flush=1, fetch_count unchanged, imem_req=1 next cycle.
- MAX_STALL=4, imem_ack never -> timeout=1 after 4 FETCH cycles, HALT, pc_en stays 0 despite redirect; reset clears timeout.
- Macro defined, redirect branch_taken=1 with target_lsb=10 -> pc_en=0, trap=1, HALT; macro undefined same stimulus -> pc_en=1, pc_src=01, trap=0.
- fetch_count preset near wrap (0xFFFFFFFF via long run or force) plus one acceptance -> 0x00000000.
